// File: rtl/oam_dma_controller_pkg.sv
// Shared types and constants for the OAM DMA controller.
package oam_dma_controller_pkg;

    typedef enum logic [1:0] {
        DmaIdle,
        DmaStart,
        DmaActive
    } dma_state_e;

    localparam logic [15:0]  DMA_REG_ADDR = 16'hFF46;
    localparam int unsigned  OAM_BYTES    = 160;
    localparam logic [7:0]   HIGH_PAGE    = 8'hFF;
    localparam logic [7:0]   ECHO_BASE_HI = 8'hE0;
    localparam logic [7:0]   ECHO_OFFSET  = 8'h20;
    localparam logic [7:0]   LAST_IDX     = 8'(OAM_BYTES - 1);

    // Echo RAM pages E0-FF alias work RAM C0-DF.
    function automatic logic [7:0] eff_src_hi(input logic [7:0] hi);
        return (hi >= ECHO_BASE_HI) ? (hi - ECHO_OFFSET) : hi;
    endfunction

endpackage

// File: rtl/oam_dma_controller_bus_mux.sv
// Combinational CPU/DMA external bus selection and blocked-read substitution.
import oam_dma_controller_pkg::*;

module dma_bus_mux (
    input  logic [1:0]  i_state,
    input  logic [7:0]  i_idx,
    input  logic [7:0]  i_src_hi,
    input  logic [1:0]  i_t_cycle,
    input  logic        i_cpu_mem_enable,
    input  logic        i_cpu_mem_write,
    input  logic [15:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_data_out,
    input  logic [7:0]  i_bus_data_in,
    output logic [7:0]  o_cpu_data_in,
    output logic        o_bus_enable,
    output logic        o_bus_write,
    output logic [15:0] o_bus_addr,
    output logic [7:0]  o_bus_data_out
);

    logic w_reg_hit;
    logic w_high;
    logic w_cpu_req;
    logic w_dma;
    logic w_cpu_slot;

    always_comb begin
        w_reg_hit  = (i_cpu_addr == DMA_REG_ADDR);
        w_high     = (i_cpu_addr[15:8] == HIGH_PAGE);
        w_cpu_req  = i_cpu_mem_enable & ~w_reg_hit;
        w_dma      = (i_state == 2'(DmaActive));
        // High-page CPU accesses borrow T-cycles 0..2; DMA always owns T3 where it samples.
        w_cpu_slot = w_cpu_req & w_high & (i_t_cycle != 2'd3);

        o_bus_enable   = w_cpu_req;
        o_bus_write    = w_cpu_req & i_cpu_mem_write;
        o_bus_addr     = i_cpu_addr;
        o_bus_data_out = i_cpu_data_out;
        o_cpu_data_in  = i_bus_data_in;

        if (w_dma && !w_cpu_slot) begin
            o_bus_enable = 1'b1;
            o_bus_write  = 1'b0;
            o_bus_addr   = {eff_src_hi(i_src_hi), i_idx};
        end

        if (w_reg_hit) begin
            o_cpu_data_in = i_src_hi;
        end else if (w_dma && !w_high) begin
            o_cpu_data_in = 8'hFF;
        end
    end

endmodule

// File: rtl/oam_dma_controller.sv
// OAM DMA sequencer: owns FF46, copies 160 bytes into OAM and arbitrates the external bus.
import oam_dma_controller_pkg::*;

module oam_dma_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  t_cycle,
    input  logic        cpu_mem_enable,
    input  logic        cpu_mem_write,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_out,
    output logic [7:0]  cpu_data_in,
    output logic        bus_enable,
    output logic        bus_write,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_data_out,
    input  logic [7:0]  bus_data_in,
    output logic        oam_write,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data,
    output logic        dma_active
);

    dma_state_e r_state;
    logic [7:0] r_src_hi;
    logic [7:0] r_idx;
    logic [7:0] r_buf;
    logic       r_pending;
    logic [7:0] r_pend_idx;

    logic w_mcycle_end;
    logic w_ff46_wr;

    assign w_mcycle_end = (t_cycle == 2'd3);
    assign w_ff46_wr    = cpu_mem_enable & cpu_mem_write & (cpu_addr == DMA_REG_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= DmaIdle;
            r_src_hi   <= '0;
            r_idx      <= '0;
            r_buf      <= '0;
            r_pending  <= 1'b0;
            r_pend_idx <= '0;
        end else if (w_mcycle_end) begin
            // The buffered byte is written this edge; a fresh read below re-arms it.
            r_pending <= 1'b0;
            case (r_state)
                DmaStart: r_state <= DmaActive;
                DmaActive: begin
                    r_buf      <= bus_data_in;
                    r_pend_idx <= r_idx;
                    r_pending  <= 1'b1;
                    r_idx      <= r_idx + 8'd1;
                    if (r_idx == LAST_IDX) begin
                        r_state <= DmaIdle;
                    end
                end
                default: ;
            endcase
            if (w_ff46_wr) begin
                r_src_hi <= cpu_data_out;
                r_idx    <= '0;
                r_state  <= DmaStart;
            end
        end
    end

    assign oam_write  = r_pending & w_mcycle_end;
    assign oam_addr   = r_pend_idx;
    assign oam_data   = r_buf;
    assign dma_active = (r_state == DmaActive) | r_pending;

    dma_bus_mux u_bus_mux (
        .i_state          (r_state),
        .i_idx            (r_idx),
        .i_src_hi         (r_src_hi),
        .i_t_cycle        (t_cycle),
        .i_cpu_mem_enable (cpu_mem_enable),
        .i_cpu_mem_write  (cpu_mem_write),
        .i_cpu_addr       (cpu_addr),
        .i_cpu_data_out   (cpu_data_out),
        .i_bus_data_in    (bus_data_in),
        .o_cpu_data_in    (cpu_data_in),
        .o_bus_enable     (bus_enable),
        .o_bus_write      (bus_write),
        .o_bus_addr       (bus_addr),
        .o_bus_data_out   (bus_data_out)
    );

endmodule
